sign_extend_pipe: RTL and testbench
===================================

SIGN_EXTEND_PIPE -- requirements
Module: sign_extend_pipe

Interface
REQ-001 Parameter WORD, default 64, SHALL set the extended data width.
REQ-002 Parameter INST_SIZE, default 32, SHALL set the instruction width; only 32 is supported.
REQ-003 Parameter STAGES, default 2, SHALL set the number of register stages; legal range 1..4.
REQ-004 Parameter SHIFT_BRANCH, default 0, SHALL left-shift B/CB offsets by 2 when 1 (byte offset) and leave them unshifted when 0 (word offset).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 flush  input  1  SHALL be the synchronous pipeline-clear request.
REQ-008 in_valid  input  1  SHALL mark that inst carries an instruction.
REQ-009 in_ready  output  1  SHALL mark that the pipe accepts inst this cycle.
REQ-010 inst  input  INST_SIZE  SHALL be the instruction to extend.
REQ-011 out_valid  output  1  SHALL mark that ex_data/fmt are valid.
REQ-012 out_ready  input  1  SHALL mark that the consumer takes the output this cycle.
REQ-013 ex_data  output  WORD  SHALL be the extended immediate.
REQ-014 fmt  output  3  SHALL be the decoded format: 0=R, 1=I, 2=D, 3=CB, 4=B.

Function
REQ-015 Decode SHALL follow this priority: inst[31:26] in {000101, 100101} -> B; inst[31:24] in {0xB4, 0xB5, 0x54} -> CB; inst[31:21] in {0x7C2, 0x7C0} -> D; inst[31:22] in {0x244, 0x344} -> I; otherwise -> R.
REQ-016 B SHALL sign-extend inst[25:0] to WORD bits.
REQ-017 CB SHALL sign-extend inst[23:5] to WORD bits.
REQ-018 D SHALL sign-extend inst[20:12] to WORD bits.
REQ-019 I SHALL zero-extend inst[21:10] to WORD bits.
REQ-020 R SHALL zero-extend the full inst to WORD bits.
REQ-021 With SHIFT_BRANCH=1, B/CB results SHALL be shifted left 2 after extension, discarding bits beyond WORD.
REQ-022 Decode SHALL be combinational ahead of stage 1; stages 2..STAGES SHALL forward data unchanged.
REQ-023 Each stage SHALL hold valid, data and fmt; a stage SHALL load when its upstream is valid and it is empty or its downstream takes its contents.
REQ-024 in_ready SHALL equal (~stage1_valid | stage1_advances) & ~flush.
REQ-025 A transfer SHALL occur only when valid and ready are both 1 at a clock edge; an unaccepted output SHALL hold ex_data/fmt stable while out_valid=1.
REQ-026 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready=1; throughput SHALL be one instruction per cycle.
REQ-027 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush.
REQ-028 With the pipe full and out_ready=0, in_ready SHALL be 0.
REQ-029 flush=1 SHALL clear every stage valid at the next edge, override a simultaneous in_valid (that input is not accepted) and override a simultaneous output transfer (that output is not consumed).

Reset
REQ-030 rst_n=0 SHALL immediately clear all stage valids, data and fmt to 0, giving out_valid=0, ex_data=0 and fmt=0.
REQ-031 Reset during operation SHALL discard all in-flight instructions.
REQ-032 in_ready SHALL be 1 during the first cycle after release when flush=0.

Verification
REQ-033 STAGES=2, SHIFT_BRANCH=0, out_ready=1, back-to-back inputs 0xF84402C9, 0xB4FFFF6B, 0x17FFFFC9, 0x8B09026A -> outputs in order 64/fmt2, -5/fmt3, -55/fmt4, 0x8B09026A/fmt0, first output 2 cycles after the first acceptance.
REQ-034 SHIFT_BRANCH=1: input 0x14000040 -> 256/fmt4; input 0xB4000109 -> 32/fmt3; input 0xF80602CB -> 96/fmt2 (D format not shifted).
REQ-035 ADDI encoding 0x91000C41 (imm12=3) -> 3/fmt1; an instruction with imm12=0xFFF -> 4095 (zero-extended, not -1).
REQ-036 out_ready=0 with continuous in_valid -> exactly STAGES instructions accepted, then in_ready=0; ex_data held stable; releasing out_ready drains all in order with none lost.
REQ-037 flush asserted with a full pipe and in_valid=1 -> next cycle out_valid=0, flushed input not accepted, in_ready=1 the following cycle.
REQ-038 rst_n pulsed low mid-stream -> out_valid, ex_data and fmt become 0 without a clock edge; no pre-reset instruction emerges after release.

Source files
------------

// File: rtl/sign_extend_pipe.sv
// sign_extend_pipe: decodes an instruction's format, extends its immediate, and carries it through a ready/valid register pipeline.
module sign_extend_pipe #(
    parameter int WORD         = 64,
    parameter int INST_SIZE    = 32,
    parameter int STAGES       = 2,
    parameter int SHIFT_BRANCH = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_SIZE-1:0] inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD-1:0]      ex_data,
    output logic [2:0]           fmt
);
    logic is_b, is_cb, is_d, is_i;
    logic [WORD-1:0] b_ext, cb_ext, d_ext, dec_data;
    logic [2:0] dec_fmt;

    assign is_b  = inst[31:26] == 6'b000101 || inst[31:26] == 6'b100101;
    assign is_cb = inst[31:24] == 8'hB4 || inst[31:24] == 8'hB5 || inst[31:24] == 8'h54;
    assign is_d  = inst[31:21] == 11'h7C2 || inst[31:21] == 11'h7C0;
    assign is_i  = inst[31:22] == 10'h244 || inst[31:22] == 10'h344;

    // Branch offsets optionally become byte offsets; the shift drops bits past WORD.
    assign b_ext  = WORD'($signed(inst[25:0])) << (SHIFT_BRANCH != 0 ? 2 : 0);
    assign cb_ext = WORD'($signed(inst[23:5])) << (SHIFT_BRANCH != 0 ? 2 : 0);
    assign d_ext  = WORD'($signed(inst[20:12]));

    assign dec_data = is_b ? b_ext : is_cb ? cb_ext : is_d ? d_ext :
                      is_i ? WORD'(inst[21:10]) : WORD'(inst);
    assign dec_fmt  = is_b ? 3'd4 : is_cb ? 3'd3 : is_d ? 3'd2 : is_i ? 3'd1 : 3'd0;

    logic [STAGES-1:0] v_q, v_d, up_v, rdy;
    logic [WORD-1:0]   d_q [STAGES];
    logic [WORD-1:0]   d_d [STAGES];
    logic [WORD-1:0]   up_d [STAGES];
    logic [2:0]        f_q [STAGES];
    logic [2:0]        f_d [STAGES];
    logic [2:0]        up_f [STAGES];
    logic              acc;

    // rdy[i]: stage i may load, i.e. it is empty or everything downstream moves.
    always_comb begin
        acc  = out_ready;
        rdy  = '0;
        up_v = '0;
        up_d = '{default: '0};
        up_f = '{default: '0};
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = acc | ~v_q[i];
            rdy[i] = acc;
        end
        up_v[0] = in_valid & ~flush;
        up_d[0] = dec_data;
        up_f[0] = dec_fmt;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
            up_f[i] = f_q[i-1];
        end
        v_d = v_q;
        d_d = d_q;
        f_d = f_q;
        for (int i = 0; i < STAGES; i++) begin
            if (rdy[i]) v_d[i] = up_v[i];
            if (rdy[i] && up_v[i]) begin
                d_d[i] = up_d[i];
                f_d[i] = up_f[i];
            end
        end
        if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i] <= '0;
                f_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
            f_q <= f_d;
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign ex_data   = d_q[STAGES-1];
    assign fmt       = f_q[STAGES-1];
endmodule

// File: tb/tb_sign_extend_pipe.sv
// tb_sign_extend_pipe: scoreboard bench running a word-offset and a byte-offset instance in lockstep.
module tb_sign_extend_pipe;
    logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] inst = '0;
    logic in_ready0, in_ready1, out_valid0, out_valid1;
    logic [63:0] ex0, ex1;
    logic [2:0] fmt0, fmt1;

    sign_extend_pipe #(.WORD(64), .INST_SIZE(32), .STAGES(2), .SHIFT_BRANCH(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .inst(inst), .out_valid(out_valid0), .out_ready(out_ready), .ex_data(ex0), .fmt(fmt0));
    sign_extend_pipe #(.WORD(64), .INST_SIZE(32), .STAGES(2), .SHIFT_BRANCH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .inst(inst), .out_valid(out_valid1), .out_ready(out_ready), .ex_data(ex1), .fmt(fmt1));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [66:0] q0[$], q1[$];
    logic ovr = 0;
    logic [66:0] ovr0, ovr1;
    logic hold = 0;
    logic [67:0] held;

    task automatic chk(string name, logic [67:0] act, logic [67:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: format and value straight from the decode rules, using integer arithmetic.
    function automatic logic [66:0] model(logic [31:0] x, bit sh);
        longint v;
        logic [2:0] f;
        if (x[31:26] == 6'b000101 || x[31:26] == 6'b100101) begin
            f = 4; v = longint'(x[25:0]);
            if (x[25]) v = v - (longint'(1) << 26);
            if (sh) v = v * 4;
        end else if (x[31:24] == 8'hB4 || x[31:24] == 8'hB5 || x[31:24] == 8'h54) begin
            f = 3; v = longint'(x[23:5]);
            if (x[23]) v = v - (longint'(1) << 19);
            if (sh) v = v * 4;
        end else if (x[31:21] == 11'h7C2 || x[31:21] == 11'h7C0) begin
            f = 2; v = longint'(x[20:12]);
            if (x[20]) v = v - 512;
        end else if (x[31:22] == 10'h244 || x[31:22] == 10'h344) begin
            f = 1; v = longint'(x[21:10]);
        end else begin
            f = 0; v = longint'(x);
        end
        return {f, 64'(v)};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] r = $urandom;
        int sel = $urandom_range(0, 5);
        if (sel == 0) return {($urandom % 2) ? 6'b000101 : 6'b100101, r[25:0]};
        if (sel == 1) return {($urandom % 2) ? 8'hB4 : 8'h54, r[23:0]};
        if (sel == 2) return {($urandom % 2) ? 11'h7C2 : 11'h7C0, r[20:0]};
        if (sel == 3) return {($urandom % 2) ? 10'h244 : 10'h344, r[21:0]};
        return r;
    endfunction

    always @(negedge clk) begin
        if (hold) chk("hold_u0", {out_valid0, fmt0, ex0}, held);
        hold = rst_n & out_valid0 & ~out_ready & ~flush;
        held = {1'b1, fmt0, ex0};
        if (rst_n && in_valid && in_ready0) begin
            q0.push_back(ovr ? ovr0 : model(inst, 0));
            q1.push_back(ovr ? ovr1 : model(inst, 1));
        end
        if (rst_n && out_ready && !flush) begin
            if (out_valid0) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL u0_unexpected: got %0h expected none", {fmt0, ex0});
                end else chk("u0_out", {fmt0, ex0}, q0.pop_front());
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL u1_unexpected: got %0h expected none", {fmt1, ex1});
                end else chk("u1_out", {fmt1, ex1}, q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        in_valid = 0; out_ready = 1; flush = 0; ovr = 0;
        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        chk(name, 68'(q0.size() + q1.size()), 0);
        step();
    endtask

    task automatic fill(output int acc);
        acc = 0; out_ready = 0; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            inst = gen();
            @(negedge clk);
            if (in_ready0) acc++;
            step();
        end
    endtask

    logic [31:0] v33[4] = '{32'hF84402C9, 32'hB4FFFF6B, 32'h17FFFFC9, 32'h8B09026A};
    logic [66:0] e33a[4] = '{{3'd2, 64'd64}, {3'd3, 64'hFFFFFFFFFFFFFFFB},
                             {3'd4, 64'hFFFFFFFFFFFFFFC9}, {3'd0, 64'h8B09026A}};
    logic [66:0] e33b[4] = '{{3'd2, 64'd64}, {3'd3, 64'hFFFFFFFFFFFFFFEC},
                             {3'd4, 64'hFFFFFFFFFFFFFF24}, {3'd0, 64'h8B09026A}};
    logic [31:0] vdir[5] = '{32'h14000040, 32'hB4000109, 32'hF80602CB, 32'h91000C41, 32'h913FFC00};
    logic [66:0] edira[5] = '{{3'd4, 64'd64}, {3'd3, 64'd8}, {3'd2, 64'd96}, {3'd1, 64'd3}, {3'd1, 64'd4095}};
    logic [66:0] edirb[5] = '{{3'd4, 64'd256}, {3'd3, 64'd32}, {3'd2, 64'd96}, {3'd1, 64'd3}, {3'd1, 64'd4095}};

    initial begin
        int acc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {out_valid0, fmt0, ex0}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", in_ready0, 1);
        step();

        out_ready = 1; ovr = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; inst = v33[k]; ovr0 = e33a[k]; ovr1 = e33b[k];
            @(negedge clk);
            if (k == 0) chk("accept_first", in_ready0, 1);
            if (k == 1) chk("latency_early", out_valid0, 0);
            if (k == 2) chk("latency_2", out_valid0, 1);
            step();
        end
        drain("drain_req33");

        ovr = 1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; inst = vdir[k]; ovr0 = edira[k]; ovr1 = edirb[k];
            @(negedge clk);
            step();
        end
        drain("drain_dir");

        fill(acc);
        chk("stall_accepts", 68'(acc), 2);
        @(negedge clk);
        chk("stall_ready", in_ready0, 0);
        step();
        drain("drain_stall");

        fill(acc);
        flush = 1; in_valid = 1; inst = gen();
        @(negedge clk);
        chk("flush_ready", in_ready0, 0);
        step();
        flush = 0; in_valid = 0;
        q0.delete(); q1.delete();
        @(negedge clk);
        chk("flush_valid", out_valid0, 0);
        chk("flush_in_ready", in_ready0, 1);
        step();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                in_valid = 1; out_ready = 1; flush = 0; inst = gen();
                step();
                in_valid = 1; inst = gen();
                step();
                rst_n = 0;
                #1;
                chk("async_rst_u0", {out_valid0, fmt0, ex0}, 0);
                chk("async_rst_u1", {out_valid1, fmt1, ex1}, 0);
                q0.delete(); q1.delete();
                in_valid = 0;
                step();
                step();
                rst_n = 1;
                @(negedge clk);
                chk("rst_release_ready", in_ready0, 1);
                step();
            end
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 40) == 0;
            inst = gen();
            step();
            if (flush) begin
                q0.delete(); q1.delete();
            end
        end
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
